// File: rtl/alu_responder.sv
// alu_responder: registered valid/ready ALU endpoint.
// Computes result and NZCV on accept, returns them in order through a small FIFO.
module alu_responder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [3:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int EW = 37;

  logic [32:0]   w_sum;
  logic [32:0]   w_dif;
  logic [31:0]   w_res;
  logic          w_c;
  logic          w_v;
  logic          w_err;
  logic [3:0]    w_flags;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [OW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_op_cnt;

  always_comb begin
    w_sum = {1'b0, req_a} + {1'b0, req_b};
    w_dif = {1'b0, req_a} + {1'b0, ~req_b} + 33'd1;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (req_op)
      4'b0000: begin
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (req_a[31] == req_b[31]) &&
                (w_sum[31] != req_a[31]);
      end
      4'b0001: begin
        w_res = w_dif[31:0];
        w_c   = w_dif[32];
        w_v   = (req_a[31] != req_b[31]) &&
                (w_dif[31] != req_a[31]);
      end
      4'b0010: w_res = req_a & req_b;
      4'b0011: w_res = req_a | req_b;
      4'b0100: w_res = req_a ^ req_b;
      4'b0101: w_res = req_a << req_b[4:0];
      4'b0110: w_res = req_a >> req_b[4:0];
      4'b0111: w_res = $signed(req_a) >>> req_b[4:0];
      4'b1011: w_res = {31'd0, $signed(req_a) < $signed(req_b)};
      4'b1101: w_res = {31'd0, req_a < req_b};
      default: w_err = 1'b1;
    endcase
    // Illegal ops report all-zero flags, so Z is suppressed too.
    w_flags = w_err ? 4'b0000
                    : {w_res[31], w_res == 32'd0, w_c, w_v};
  end

  assign req_ready = (r_cnt < OW'(DEPTH));
  assign rsp_valid = (r_cnt != '0);
  assign w_push    = req_valid & req_ready;
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_head    = r_mem[r_rd];

  assign rsp_result = rsp_valid ? w_head[36:5] : 32'd0;
  assign rsp_flags  = rsp_valid ? w_head[4:1]  : 4'd0;
  assign rsp_err    = rsp_valid ? w_head[0]    : 1'b0;
  assign op_count   = r_op_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_op_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_res, w_flags, w_err};
        r_wr        <= r_wr + AW'(1);
        r_op_cnt    <= r_op_cnt + CNT_W'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + OW'(1);
        2'b01:   r_cnt <= r_cnt - OW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: directed and randomized checks of alu_responder
// against an arithmetic reference model and a response queue.
module tb_alu_responder;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] op_count;

  int          n_tests;
  int          n_fail;
  logic [15:0] exp_cnt;

  alu_responder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  // Reference: wide integer arithmetic, carry/overflow by range test.
  function automatic rsp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    rsp_t   r;
    longint ua, ub, sa, sb, s;
    logic   c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      4'd0: begin
        s = ua + ub;
        r.res = s[31:0];
        c = (s > 64'sd4294967295);
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s = ua - ub;
        r.res = s[31:0];
        c = (ua >= ub);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r.res = a & b;
      4'd3:  r.res = a | b;
      4'd4:  r.res = a ^ b;
      4'd5:  r.res = a << b[4:0];
      4'd6:  r.res = a >> b[4:0];
      4'd7: begin
        s = sa >>> b[4:0];
        r.res = s[31:0];
      end
      4'd11: r.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd13: r.res = (ua < ub) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    if (!r.err) r.fl = {r.res[31], r.res == 32'd0, c, v};
    return r;
  endfunction

  // Single request into an empty FIFO; samples one cycle after accept.
  task automatic do_one(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b,
                        output rsp_t got, output logic vld);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    vld       = rsp_valid;
    got       = {rsp_result, rsp_flags, rsp_err};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    exp_cnt   = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b cnt=%0d want 0 0",
               rsp_valid, op_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b res=%h want 1 0 0",
               req_ready, rsp_valid, rsp_result);
    end
  endtask

  task automatic test_basic_ops();
    logic [3:0] ops [10];
    rsp_t       got;
    rsp_t       exp;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'hB, 4'hD};
    rsp_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = {32'd0, (ops[i-1] == 4'h1) ? 4'b0110 : 4'b0100, 1'b0};
        got = {rsp_result, rsp_flags, rsp_err};
        n_tests++;
        if (rsp_valid !== 1'b1 || got !== exp) begin
          n_fail++;
          $display("FAIL basic_op%h: vld=%b got=%h want vld=1 %h",
                   ops[i-1], rsp_valid, got, exp);
        end
      end
      if (i < 10) begin
        req_valid = 1'b1;
        req_op    = ops[i];
        req_a     = 32'd0;
        req_b     = 32'd0;
        exp_cnt   = exp_cnt + 16'd1;
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_tests++;
    if (op_count !== 16'd10 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_count: cnt=%0d vld=%b want 10 0",
               op_count, rsp_valid);
    end
  endtask

  task automatic test_arith();
    logic [3:0]  ops [5];
    logic [31:0] res [5];
    logic [3:0]  fl  [5];
    rsp_t        got;
    logic        vld;
    ops = '{4'h0, 4'h1, 4'hB, 4'hD, 4'h5};
    res = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0};
    fl  = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      do_one(ops[i], 32'd0, 32'd1, got, vld);
      n_tests++;
      if (vld !== 1'b1 || got !== {res[i], fl[i], 1'b0}) begin
        n_fail++;
        $display("FAIL arith_op%h: vld=%b got=%h want %h",
                 ops[i], vld, got, {res[i], fl[i], 1'b0});
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  ops [4];
    logic [31:0] res [4];
    logic [3:0]  fl  [4];
    rsp_t        got;
    logic        vld;
    ops = '{4'h0, 4'h1, 4'h7, 4'hB};
    res = '{32'h8000_0000, 32'h7FFF_FFFE, 32'h3FFF_FFFF, 32'd0};
    fl  = '{4'b1001, 4'b0010, 4'b0000, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      do_one(ops[i], 32'h7FFF_FFFF, 32'd1, got, vld);
      n_tests++;
      if (vld !== 1'b1 || got !== {res[i], fl[i], 1'b0}) begin
        n_fail++;
        $display("FAIL ovf_op%h: vld=%b got=%h want %h",
                 ops[i], vld, got, {res[i], fl[i], 1'b0});
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t e0, e1, e2, got;
    e0 = model(4'h0, 32'd10, 32'd20);
    e1 = model(4'h1, 32'd5, 32'd9);
    e2 = model(4'h4, 32'hFF, 32'h0F);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = 4'h0; req_a = 32'd10; req_b = 32'd20;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rdy0: rdy=%b want 1", req_ready);
    end
    @(negedge clk);
    got = {rsp_result, rsp_flags, rsp_err};
    n_tests++;
    if (rsp_valid !== 1'b1 || got !== e0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: vld=%b rdy=%b got=%h want 1 1 %h",
               rsp_valid, req_ready, got, e0);
    end
    req_op = 4'h1; req_a = 32'd5; req_b = 32'd9;
    @(negedge clk);
    got = {rsp_result, rsp_flags, rsp_err};
    n_tests++;
    if (req_ready !== 1'b0 || got !== e0) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b got=%h want 0 %h",
               req_ready, got, e0);
    end
    req_op = 4'h4; req_a = 32'hFF; req_b = 32'h0F;
    @(negedge clk);
    got = {rsp_result, rsp_flags, rsp_err};
    n_tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || got !== e0) begin
      n_fail++;
      $display("FAIL bp_hold: rdy=%b vld=%b got=%h want 0 1 %h",
               req_ready, rsp_valid, got, e0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    got = {rsp_result, rsp_flags, rsp_err};
    n_tests++;
    if (req_ready !== 1'b1 || got !== e1) begin
      n_fail++;
      $display("FAIL bp_pop1: rdy=%b got=%h want 1 %h",
               req_ready, got, e1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    got = {rsp_result, rsp_flags, rsp_err};
    n_tests++;
    if (rsp_valid !== 1'b1 || got !== e2) begin
      n_fail++;
      $display("FAIL bp_third: vld=%b got=%h want 1 %h",
               rsp_valid, got, e2);
    end
    exp_cnt = exp_cnt + 16'd3;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || op_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL bp_drain: vld=%b cnt=%0d want 0 %0d",
               rsp_valid, op_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    rsp_t got;
    logic vld;
    do_one(4'hF, 32'd5, 32'd3, got, vld);
    n_tests++;
    if (vld !== 1'b1 || got !== {32'd0, 4'b0000, 1'b1} ||
        op_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL illegal: vld=%b got=%h cnt=%0d want 1 %h %0d",
               vld, got, op_count, {32'd0, 4'b0000, 1'b1}, exp_cnt);
    end
    do_one(4'h0, 32'd5, 32'd3, got, vld);
    n_tests++;
    if (vld !== 1'b1 || got !== {32'd8, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_next: vld=%b got=%h want 1 %h",
               vld, got, {32'd8, 4'b0000, 1'b0});
    end
  endtask

  task automatic test_random();
    rsp_t q[$];
    rsp_t got;
    bit   push, pop;
    push = 1'b0;
    pop  = 1'b0;
    for (int n = 0; n < 420; n++) begin
      @(negedge clk);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(model(req_op, req_a, req_b));
        exp_cnt = exp_cnt + 16'd1;
      end
      got = {rsp_result, rsp_flags, rsp_err};
      n_tests++;
      if (rsp_valid !== (q.size() > 0) ||
          req_ready !== (q.size() < 2) || op_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL rnd_ctl@%0d: vld=%b rdy=%b cnt=%0d want occ=%0d cnt=%0d",
                 n, rsp_valid, req_ready, op_count, q.size(), exp_cnt);
      end
      n_tests++;
      if (q.size() > 0 ? (got !== q[0]) : (got !== '0)) begin
        n_fail++;
        $display("FAIL rnd_data@%0d: got=%h want %h",
                 n, got, q.size() > 0 ? q[0] : '0);
      end
      if (n < 400) begin
        req_valid = ($urandom_range(0, 3) != 0);
        rsp_ready = ($urandom_range(0, 3) != 0);
        req_op    = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: req_a = 32'h7FFF_FFFF;
          1: req_a = 32'h8000_0000;
          default: req_a = $urandom;
        endcase
        req_b = ($urandom_range(0, 3) == 0) ? req_a : $urandom;
      end else begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      push = req_valid && (q.size() < 2);
      pop  = rsp_ready && (q.size() > 0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = 4'h0; req_a = 32'd1; req_b = 32'd2;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fill: vld=%b rdy=%b want 1 0",
               rsp_valid, req_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    n_tests++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0 ||
        rsp_result !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_async: vld=%b cnt=%0d res=%h want 0 0 0",
               rsp_valid, op_count, rsp_result);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
          op_count !== 16'd0) begin
        n_fail++;
        $display("FAIL mid_after%0d: vld=%b rdy=%b cnt=%0d want 0 1 0",
                 i, rsp_valid, req_ready, op_count);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_ops();
    test_arith();
    test_overflow();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_responder.md
Name: alu_responder

Overview:
- Registered, handshaked front end for 32-bit ALU operations.
- An initiator presents an operand pair and an opcode on a valid/ready request channel. The block computes the result and NZCV flags, queues the response in a small FIFO, and returns it on a valid/ready response channel.
- It is the responder end of the ALU request/response interface. It gives the datapath and bench a backpressurable, cycle-accurate ALU endpoint in place of a purely combinational one.

Parameters:
- DEPTH, 2, response FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the accepted-request counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_a  input  32  operand A.
- req_b  input  32  operand B.
- req_op  input  4  opcode.
- rsp_valid  output  1  response at FIFO head.
- rsp_ready  input  1  consumer takes response.
- rsp_result  output  32  result.
- rsp_flags  output  4  {N,Z,C,V}.
- rsp_err  output  1  opcode was illegal.
- op_count  output  CNT_W  accepted requests, modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - FIFO emptied, pointers and occupancy cleared, op_count=0.
  - rsp_valid=0, req_ready=1 once rst_n is released.
  - In-flight entries are discarded, not delivered.
- Accept: req_valid & req_ready at a rising edge.
  - The result is computed combinationally from req_a/req_b/req_op that cycle and written to the FIFO tail.
  - op_count increments.
- Deliver: rsp_valid & rsp_ready at a rising edge pops the head.
- req_ready = (occupancy < DEPTH). It has no combinational dependence on rsp_ready.
- rsp_valid = (occupancy > 0).
- rsp_result, rsp_flags and rsp_err come from the head entry. All three are driven 0 when rsp_valid=0.
- rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- Latency: a request accepted at edge t is visible on rsp_* in the cycle after edge t if the FIFO was empty. Otherwise responses are strictly in request order.
- Throughput: one request and one response per cycle sustained.
- Simultaneous push and pop with 0<occupancy<DEPTH: occupancy unchanged.
- When full: no push occurs. A pop that cycle makes req_ready=1 in the next cycle.
- When empty and a push occurs: rsp_valid rises next cycle. There is no same-cycle bypass.
- op_count wraps from all-ones to 0 with no flag.
- Opcodes (all 32-bit, unsigned unless noted):
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL: A<<B[4:0]
  - 0110 SRL: A>>B[4:0], logical
  - 0111 SRA: A>>>B[4:0], arithmetic
  - 1011 SLT: 1 if signed A<B, else 0
  - 1101 SLTU: 1 if unsigned A<B, else 0
  - All other codes are illegal: result 0, flags 0000, rsp_err=1. The request is still accepted, counted and answered.
- Flags:
  - N = result[31]; Z = (result==0).
  - ADD: C = carry out of bit 31; V = signed overflow (A[31]==B[31] and result[31]!=A[31]).
  - SUB: computed as A+~B+1. C = carry out (1 means no borrow, i.e. A≥B unsigned). V = A[31]!=B[31] and result[31]!=A[31].
  - All other legal ops: C=0, V=0.

Test Plan:
1. Reset and basic ops:
   - Stimulus: reset, then with rsp_ready=1 send A=0,B=0 for ops 0000,0001,0010,0011,0100,0101,0110,0111,1011,1101 back-to-back.
   - Required: each response arrives 1 cycle after accept, in order. Result 0 for all. Flags: ADD 0100; SUB 0110; all others 0100. op_count=10.
2. Arithmetic and compares, A=0,B=1:
   - ADD: result 1, flags 0000.
   - SUB: result 0xFFFFFFFF, flags 1000.
   - SLT: result 1, flags 0000.
   - SLTU: result 1, flags 0000.
   - SLL: result 0, flags 0100.
3. Overflow and shifts, A=0x7FFFFFFF,B=1:
   - ADD: result 0x80000000, flags 1001.
   - SUB: result 0x7FFFFFFE, flags 0010.
   - SRA: result 0x3FFFFFFF.
   - SLT: result 0, flags 0100.
4. Backpressure:
   - Stimulus: hold rsp_ready=0 and offer 3 requests.
   - Required: req_ready drops after DEPTH=2 accepts, and the third request is held. rsp_* hold the first response steady.
   - Then set rsp_ready=1: order is preserved, the third request is accepted the cycle after the first pop, and no response is lost or duplicated.
5. Illegal op:
   - Stimulus: req_op=1111 with A=5,B=3.
   - Required: rsp_err=1, result 0, flags 0000, op_count increments. The next legal op returns rsp_err=0.
6. Reset mid-operation:
   - Stimulus: FIFO full, assert rst_n=0 between clock edges.
   - Required: rsp_valid and op_count clear immediately. After release req_ready=1, and no stale responses appear.
